// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, data widths and the
// header length range check.
package loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned LEN_W  = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLenHi,
      StLenLo,
      StDataHi,
      StDataLo,
      StChk,
      StDone,
      StError
   } state_e;

   // True when a word count cannot be addressed with addr_w bits (len > 2^addr_w).
   function automatic logic len_too_long(input logic [LEN_W-1:0] len, input int unsigned addr_w);
      logic [LEN_W:0] w_limit;
      w_limit = (LEN_W+1)'(1) << addr_w;
      return {1'b0, len} > w_limit;
   endfunction

endpackage

// File: rtl/byte_pack.sv
// Two-byte to 16-bit word assembler: latches the high byte, then on the low-byte strobe
// registers the full word and raises a one-cycle write strobe.
module byte_pack
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cap_hi,
   input  logic              i_cap_lo,
   input  logic [BYTE_W-1:0] i_byte,
   output logic              o_wen,
   output logic [WORD_W-1:0] o_word
);

   logic [BYTE_W-1:0] r_hi;
   logic [WORD_W-1:0] r_word;
   logic              r_wen;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hi   <= '0;
         r_word <= '0;
         r_wen  <= 1'b0;
      end else begin
         r_wen <= i_cap_lo;
         if (i_cap_hi) r_hi <= i_byte;
         // Word holds its last value between strobes.
         if (i_cap_lo) r_word <= {r_hi, i_byte};
      end
   end

   assign o_wen  = r_wen;
   assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it into instruction memory
// while holding the CPU in reset. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_cnt
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [LEN_W-1:0]  r_len;
   logic [15:0]       r_word_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  w_len_full;
   logic [WORD_W-1:0] w_word;
   logic              w_xfer;
   logic              w_start;
   logic              w_cap_hi;
   logic              w_cap_lo;
   logic              w_last;
   logic              w_wen;

   assign in_ready   = r_state inside {StLenHi, StLenLo, StDataHi, StDataLo, StChk};
   assign w_xfer     = in_valid & in_ready;
   assign w_start    = start & (r_state inside {StIdle, StDone, StError});
   assign w_len_full = {r_len[LEN_W-1:BYTE_W], in_data};
   // word_cnt counts completed words, so the word now finishing is the last one when +1 == len.
   assign w_last     = (r_word_cnt + 16'd1) == r_len;
   assign w_cap_hi   = w_xfer & (r_state == StDataHi);
   assign w_cap_lo   = w_xfer & (r_state == StDataLo);

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_csum <= '0;
      end else if (w_start) begin
         r_csum <= '0;
      end else if (w_xfer && r_state != StChk) begin
         r_csum <= r_csum ^ in_data;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle, StDone, StError: if (start) w_state_nxt = StLenHi;
         StLenHi:                 if (w_xfer) w_state_nxt = StLenLo;
         StLenLo: begin
            if (w_xfer) begin
               if (w_len_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_state_nxt = StChk;
`else
                  w_state_nxt = StDone;
`endif
               end else if (len_too_long(w_len_full, ADDR_W)) begin
                  w_state_nxt = StError;
               end else begin
                  w_state_nxt = StDataHi;
               end
            end
         end
         StDataHi:                if (w_xfer) w_state_nxt = StDataLo;
         StDataLo: begin
            if (w_xfer) begin
               if (!w_last) begin
                  w_state_nxt = StDataHi;
               end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_state_nxt = StChk;
`else
                  w_state_nxt = StDone;
`endif
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk: if (w_xfer) w_state_nxt = (in_data == r_csum) ? StDone : StError;
`endif
         default:                 w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_len      <= '0;
         r_word_cnt <= '0;
         r_addr     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_word_cnt <= '0;
         end else if (w_cap_lo) begin
            r_word_cnt <= r_word_cnt + 16'd1;
            r_addr     <= r_word_cnt[ADDR_W-1:0];
         end
         if (w_xfer && r_state == StLenHi) r_len[LEN_W-1:BYTE_W] <= in_data;
         if (w_xfer && r_state == StLenLo) r_len[BYTE_W-1:0]     <= in_data;
      end
   end

   byte_pack u_byte_pack (
      .clk      (clk),
      .rst      (rst),
      .i_cap_hi (w_cap_hi),
      .i_cap_lo (w_cap_lo),
      .i_byte   (in_data),
      .o_wen    (w_wen),
      .o_word   (w_word)
   );

   assign mem_wen   = w_wen;
   assign mem_addr  = r_addr;
   assign mem_wdata = w_word;
   assign word_cnt  = r_word_cnt;
   // DONE is entered together with the final write pulse; report it once that pulse is over.
   assign done      = (r_state == StDone) & ~w_wen;
   assign cpu_hold  = ~done;
   assign error     = (r_state == StError);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader (ADDR_W=4) with an expected-write queue model
// and directed cases; honours IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

   localparam int unsigned AW = 4;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          start    = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data  = 8'h00;
   logic          in_ready;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [15:0]   word_cnt;

   imem_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .error     (error),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t           exp_q[$];
   logic [7:0]    stim_q[$];
   logic [15:0]   tb_mem [0:(2**AW)-1];
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [AW-1:0] last_addr = '0;
   logic [15:0]   last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic wr_t mk(input int a, input logic [15:0] d);
      wr_t e;
      e.addr = a[AW-1:0];
      e.data = d;
      return e;
   endfunction

   // Every write must match the head of the expected queue; outputs hold between writes.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (mem_wen) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                           mem_addr, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 32'(mem_addr), 32'(e.addr));
                  check("wr_data", 32'(mem_wdata), 32'(e.data));
               end
               tb_mem[mem_addr] = mem_wdata;
            end else begin
               check("addr_hold", 32'(mem_addr), 32'(last_addr));
               check("data_hold", 32'(mem_wdata), 32'(last_data));
            end
            check("hold_is_not_done", 32'(cpu_hold), 32'(!done));
            check("done_and_error", 32'(done & error), 32'd0);
         end
         last_addr = mem_addr;
         last_data = mem_wdata;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL byte_accept_timeout: in_ready got 0, required 1 (t=%0t)", $time);
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_stim(input bit gaps);
      foreach (stim_q[k]) send_byte(stim_q[k], gaps);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_ready", 32'(in_ready), 32'd1);
      check("start_cnt", 32'(word_cnt), 32'd0);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_flags", 32'({done, error}), 32'd0);
   endtask

   task automatic wait_end(input bit exp_err, input logic [15:0] exp_cnt, input string tag);
      int n;
      n = 0;
      while (!(done || error) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, 32'(done), 32'(!exp_err));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_cnt"}, 32'(word_cnt), 32'(exp_cnt));
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Model: header, then words (if length fits), then XOR of everything sent when enabled.
   task automatic run_load(input logic [15:0] len, input bit gaps, input bit bad_chk);
      logic [15:0] w;
      logic [7:0]  x;
      bit          too_long;
      bit          exp_err;
      too_long = (len > 16'(2**AW));
      exp_err  = too_long;
      stim_q.delete();
      stim_q.push_back(len[15:8]);
      stim_q.push_back(len[7:0]);
      if (!too_long) begin
         for (int i = 0; i < int'(len); i++) begin
            w = 16'($urandom);
            stim_q.push_back(w[15:8]);
            stim_q.push_back(w[7:0]);
            exp_q.push_back(mk(i, w));
         end
      end
      x = 8'h00;
      foreach (stim_q[k]) x ^= stim_q[k];
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!too_long) begin
         if (bad_chk) begin
            x ^= 8'($urandom_range(1, 255));
            exp_err = 1'b1;
         end
         stim_q.push_back(x);
      end
`else
      if (bad_chk && x == 8'h00) exp_err = too_long;
`endif
      do_start();
      send_stim(gaps);
      wait_end(exp_err, too_long ? 16'd0 : len, "load");
   endtask

   task automatic load_1234_abcd();
      exp_q.push_back(mk(0, 16'h1234));
      exp_q.push_back(mk(1, 16'hABCD));
      stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      do_start();
      send_stim(1'b0);
      check("w1_wen", 32'(mem_wen), 32'd1);
      check("w1_addr", 32'(mem_addr), 32'd1);
      check("w1_data", 32'(mem_wdata), 32'hABCD);
      check("w1_hold", 32'(cpu_hold), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h42, 1'b0);
`else
      @(negedge clk);
`endif
      check("after_w1_done", 32'(done), 32'd1);
      check("after_w1_hold", 32'(cpu_hold), 32'd0);
      check("after_w1_wen", 32'(mem_wen), 32'd0);
      check("after_w1_cnt", 32'(word_cnt), 32'd2);
      check("mem0", 32'(tb_mem[0]), 32'h1234);
      check("mem1", 32'(tb_mem[1]), 32'hABCD);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] len;
      #12;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_wen", 32'(mem_wen), 32'd0);
      check("rst_flags", 32'({done, error}), 32'd0);
      check("rst_cnt", 32'(word_cnt), 32'd0);
      check("rst_addr_data", 32'({mem_addr, mem_wdata}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      load_1234_abcd();

      // Zero-length load.
      stim_q = '{8'h00, 8'h00};
      do_start();
      send_stim(1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h00, 1'b0);
      wait_end(1'b0, 16'd0, "zero_chk_ok");
      do_start();
      send_stim(1'b0);
      send_byte(8'h01, 1'b0);
      wait_end(1'b1, 16'd0, "zero_chk_bad");

      exp_q.push_back(mk(0, 16'h5AA5));
      stim_q = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'h00};
      do_start();
      send_stim(1'b0);
      wait_end(1'b1, 16'd1, "chk_mismatch");
      check("chk_mismatch_hold", 32'(cpu_hold), 32'd1);
      exp_q.push_back(mk(0, 16'h5AA5));
      stim_q = '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFE};
      do_start();
      send_stim(1'b0);
      wait_end(1'b0, 16'd1, "chk_match");
`else
      check("zero_done_now", 32'(done), 32'd1);
      wait_end(1'b0, 16'd0, "zero");
`endif

      // Length one past the address space aborts straight after the header.
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h11, 1'b0);
      check("len17_error_now", 32'(error), 32'd1);
      check("len17_ready", 32'(in_ready), 32'd0);
      wait_end(1'b1, 16'd0, "len17");
      run_load(16'h0010, 1'b0, 1'b0);
      check("len16_cnt", 32'(word_cnt), 32'd16);

      // Reset between the two bytes of word 1.
      tb_mem[1] = 16'hDEAD;
      exp_q.push_back(mk(0, 16'h1234));
      stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
      do_start();
      send_stim(1'b0);
      #2 rst = 1'b0;
      #1;
      check("arst_wen", 32'(mem_wen), 32'd0);
      check("arst_addr", 32'(mem_addr), 32'd0);
      check("arst_data", 32'(mem_wdata), 32'd0);
      check("arst_cnt", 32'(word_cnt), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd0);
      check("arst_hold", 32'(cpu_hold), 32'd1);
      check("arst_flags", 32'({done, error}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("arst_pending", 32'(exp_q.size()), 32'd0);
      check("arst_no_word1", 32'(tb_mem[1]), 32'hDEAD);
      load_1234_abcd();

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) len = 16'($urandom_range(0, 20));
         else                           len = 16'($urandom_range(1, 16));
         run_load(len, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
